dcache_qspi: RTL and testbench

Line-transfer engine on the memory side of the data cache: services the cache's `push` (write-back) and `pull` (line fill) requests by running one QPI-mode PSRAM transaction per line. It consumes the cache's nibble stream through `dwrite`/`rstrobe_d` and returns fill data through `dread`/`wstrobe_d`, presenting exactly 2·LINE_LENGTH strobes per line in the cache's nibble order. It sits between `dcache` and the chip's 4-bit QSPI pads.

---
 rtl/dcache_pkg.sv | 11 +
 rtl/dcache_qspi_if.sv | 21 ++
 rtl/dcache_qspi_phy.sv | 30 +++
 rtl/dcache_qspi.sv | 104 ++++++++++
 tb/tb_dcache_qspi.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and constants for the data-cache memory-side engine
package dcache_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_WAIT, S_DATA, S_END} state_t;
  localparam logic [7:0] CMD_READ = 8'hEB;
  localparam logic [7:0] CMD_WRITE = 8'h38;
  localparam int ADDR_NIBBLES = 6;
  // nibble i of a line in cache order: byte 0 high, byte 0 low, byte 1 high, ...
  function automatic logic [3:0] line_nibble(input logic [63:0] line, input int unsigned i);
    return 4'(line >> (8 * (i / 2) + ((i % 2) != 0 ? 0 : 4)));
  endfunction
endpackage

// File: rtl/dcache_qspi_if.sv
// dcache_qspi_if: cache-side handshake and QSPI pad bundle of the line-transfer engine
interface dcache_qspi_if #(
  parameter int PA = 22,
  parameter int LINE_LENGTH = 4
);
  localparam int TW = PA - $clog2(LINE_LENGTH);
  logic start, push, pull;
  logic [TW-1:0] tag;
  logic [3:0] dwrite, dread;
  logic wstrobe_d, rstrobe_d, busy, done;
  logic qspi_cs_n, qspi_sclk;
  logic [3:0] qspi_oe, qspi_out, qspi_in;
  modport master (
    output start, push, pull, tag, dwrite, qspi_in,
    input dread, wstrobe_d, rstrobe_d, busy, done, qspi_cs_n, qspi_sclk, qspi_oe, qspi_out
  );
  modport slave (
    input start, push, pull, tag, dwrite, qspi_in,
    output dread, wstrobe_d, rstrobe_d, busy, done, qspi_cs_n, qspi_sclk, qspi_oe, qspi_out
  );
endinterface

// File: rtl/dcache_qspi_phy.sv
// qspi_phy: SCLK phase toggle plus registered pad outputs and input sampler
module qspi_phy (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       load,
  input  logic [3:0] din,
  input  logic       oe_load,
  input  logic [3:0] oe_d,
  input  logic       sample_en,
  input  logic [3:0] pin,
  output logic       sclk,
  output logic [3:0] oe,
  output logic [3:0] pout,
  output logic [3:0] sample
);
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk <= 1'b0;
      oe <= 4'h0;
      pout <= 4'h0;
      sample <= 4'h0;
    end else begin
      sclk <= run ? ~sclk : 1'b0;
      if (load) pout <= din;
      if (oe_load) oe <= oe_d;
      if (sample_en) sample <= pin;
    end
  end
endmodule

// File: rtl/dcache_qspi.sv
// dcache_qspi: services dcache push/pull with one QPI PSRAM transaction per line
module dcache_qspi #(
  parameter int PA = 22,
  parameter int LINE_LENGTH = 4,
  parameter int WAIT_CYCLES = 6
) (
  input logic clk,
  input logic reset,
  dcache_qspi_if.slave bus
);
  import dcache_pkg::*;
  localparam int OFS = $clog2(LINE_LENGTH);
  localparam logic [3:0] DATA_LAST = 4'(2 * LINE_LENGTH - 1);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] ADDR_LAST = 4'(ADDR_NIBBLES - 1);
  state_t state;
  logic [3:0] cnt, din, oe, pout, samp;
  logic [31:0] sh;
  logic [7:0] cmd;
  logic [PA-1:0] byte_addr;
  logic wr, busy, done, cs_n, rstrobe, wstrobe, phase;
  logic go, adv, last, shift, wdata, load, oe_load, sample;
  // adv marks the last clk of an SCLK period: the next edge enters phase 0
  always_comb begin
    cmd = bus.push ? CMD_WRITE : CMD_READ;
    byte_addr = {bus.tag, {OFS{1'b0}}};
    go = state == S_IDLE && bus.start && (bus.push || bus.pull);
    adv = busy && phase;
    last = adv && cnt == 4'd0;
    shift = adv && (state == S_CMD || (state == S_ADDR && cnt != 4'd0));
    wdata = adv && wr && (state == S_ADDR ? cnt == 4'd0 : state == S_DATA && cnt != 4'd0);
    load = go || shift || wdata;
    din = go ? cmd[7:4] : wdata ? bus.dwrite : sh[31:28];
    oe_load = go || (last && (state == S_DATA || (state == S_ADDR && !wr)));
    sample = adv && state == S_DATA && !wr;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt <= 4'd0;
      wr <= 1'b0;
      sh <= 32'h0;
      busy <= 1'b0;
      done <= 1'b0;
      cs_n <= 1'b1;
      rstrobe <= 1'b0;
      wstrobe <= 1'b0;
    end else begin
      done <= 1'b0;
      rstrobe <= wdata;
      wstrobe <= sample;
      if (shift) sh <= {sh[27:0], 4'h0};
      if (adv) cnt <= cnt - 4'd1;
      if (go) begin
        state <= S_CMD;
        cnt <= 4'd1;
        wr <= bus.push;
        sh <= {cmd[3:0], 24'(byte_addr), 4'h0};
        busy <= 1'b1;
        cs_n <= 1'b0;
      end else if (last) begin
        case (state)
          S_CMD: begin
            state <= S_ADDR;
            cnt <= ADDR_LAST;
          end
          S_ADDR: begin
            state <= wr ? S_DATA : S_WAIT;
            cnt <= wr ? DATA_LAST : WAIT_LAST;
          end
          S_WAIT: begin
            state <= S_DATA;
            cnt <= DATA_LAST;
          end
          S_DATA: begin
            state <= S_END;
            cnt <= 4'd1;
            cs_n <= 1'b1;
          end
          S_END: begin
            state <= S_IDLE;
            busy <= 1'b0;
            done <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
  qspi_phy phy (
    .clk(clk), .reset(reset), .run(busy), .load(load), .din(din),
    .oe_load(oe_load), .oe_d({4{go}}), .sample_en(sample), .pin(bus.qspi_in),
    .sclk(phase), .oe(oe), .pout(pout), .sample(samp)
  );
  assign bus.dread = samp;
  assign bus.wstrobe_d = wstrobe;
  assign bus.rstrobe_d = rstrobe;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.qspi_cs_n = cs_n;
  assign bus.qspi_sclk = phase;
  assign bus.qspi_oe = oe;
  assign bus.qspi_out = pout;
endmodule

// File: tb/tb_dcache_qspi.sv
// tb_dcache_qspi: directed checks of dcache_qspi against a PSRAM bus model and dcache nibble model
module tb_dcache_qspi;
  import dcache_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0, errors = 0;
  int unsigned woff = 0;
  int nw = 0, nr = 0, nboth = 0, hi_run = 0, last_run = 0;
  int lat, sw, sr, nd;
  logic [31:0] wline = 32'hA1B2C3D4;
  logic [7:0] bus_q[$];
  logic [3:0] rd_q[$];
  dcache_qspi_if #(.PA(22), .LINE_LENGTH(4)) bus ();
  dcache_qspi #(.PA(22), .LINE_LENGTH(4), .WAIT_CYCLES(6)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // dcache side: presents the nibble at its offset, advancing on each rstrobe_d
  always @(posedge clk) woff <= reset ? 0 : (bus.rstrobe_d ? (woff + 1) % 8 : woff);
  assign bus.dwrite = line_nibble(64'(wline), woff);
  always @(posedge clk) begin
    if (bus.wstrobe_d) begin
      nw++;
      rd_q.push_back(bus.dread);
    end
    if (bus.rstrobe_d) nr++;
    if (bus.wstrobe_d && bus.rstrobe_d) nboth++;
  end
  function automatic logic is_read();
    return bus_q.size() >= 2 && bus_q[0][3:0] == 4'hE && bus_q[1][3:0] == 4'hB;
  endfunction
  // PSRAM side: records one {oe,out} per rising SCLK, returns 1..8 after 14 read SCLKs
  always @(negedge clk) begin
    if (bus.qspi_cs_n) begin
      hi_run++;
      bus.qspi_in = 4'h0;
    end else begin
      if (hi_run > 0) last_run = hi_run;
      hi_run = 0;
      if (bus.qspi_sclk) bus_q.push_back({bus.qspi_oe, bus.qspi_out});
      else bus.qspi_in = (is_read() && bus_q.size() >= 14 && bus_q.size() < 22) ? 4'(bus_q.size() - 13) : 4'h0;
    end
  end
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  function automatic logic [31:0] pack_bus(input int from);
    logic [31:0] v = 32'h0;
    for (int k = 0; k < 8; k++) v = {v[27:0], (from + k < bus_q.size()) ? bus_q[from + k][3:0] : 4'h0};
    return v;
  endfunction
  function automatic logic [31:0] pack_rd();
    logic [31:0] v = 32'h0;
    for (int k = 0; k < 8; k++) v = {v[27:0], (k < rd_q.size()) ? rd_q[k] : 4'h0};
    return v;
  endfunction
  function automatic int oe_bad(input int n_out);
    int b = 0;
    for (int k = 0; k < bus_q.size(); k++) if (bus_q[k][7:4] != (k < n_out ? 4'hF : 4'h0)) b++;
    return b;
  endfunction
  // call at a negedge; returns clk cycles from start to done, tag is disturbed mid-transaction
  task automatic txn(input logic p, input logic l, input logic [19:0] t, output int n);
    bus_q.delete();
    rd_q.delete();
    bus.start = 1'b1;
    bus.push = p;
    bus.pull = l;
    bus.tag = t;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        bus.start = 1'b0;
        bus.push = 1'b0;
      end
      if (n == 10) bus.tag = ~t;
    end while (!bus.done && n < 200);
    bus.pull = 1'b0;
    chk("done_seen", n < 200, 1);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.push = 1'b0;
    bus.pull = 1'b0;
    bus.tag = '0;
    repeat (3) @(negedge clk);
    chk("rst_pads", {bus.qspi_cs_n, bus.qspi_sclk, bus.qspi_oe, bus.qspi_out}, 10'h200);
    chk("rst_ctl", {bus.busy, bus.done, bus.wstrobe_d, bus.rstrobe_d}, 0);
    chk("rst_dread", bus.dread, 0);
    reset = 1'b0;
    @(negedge clk);
    // pull of tag 0x00012
    sw = nw; sr = nr;
    txn(1'b0, 1'b1, 20'h00012, lat);
    chk("pull_lat", lat, 49);
    chk("pull_cmdaddr", pack_bus(0), 32'hEB000048);
    chk("pull_sclks", bus_q.size(), 22);
    chk("pull_oe", oe_bad(8), 0);
    chk("pull_dread", pack_rd(), 32'h12345678);
    chk("pull_wstrobes", nw - sw, 8);
    chk("pull_rstrobes", nr - sr, 0);
    @(negedge clk);
    chk("done_pulse", bus.done, 0);
    // push of tag 0x12345 with line A1B2C3D4
    sw = nw; sr = nr;
    txn(1'b1, 1'b0, 20'h12345, lat);
    chk("push_lat", lat, 37);
    chk("push_cmdaddr", pack_bus(0), 32'h38048D14);
    chk("push_data", pack_bus(8), 32'hD4C3B2A1);
    chk("push_sclks", bus_q.size(), 16);
    chk("push_oe", oe_bad(16), 0);
    chk("push_rstrobes", nr - sr, 8);
    chk("push_wstrobes", nw - sw, 0);
    // push and pull together: write wins, held pull is ignored
    sw = nw; sr = nr;
    txn(1'b1, 1'b1, 20'h00000, lat);
    chk("both_lat", lat, 37);
    chk("both_cmdaddr", pack_bus(0), 32'h38000000);
    chk("both_rstrobes", nr - sr, 8);
    chk("both_wstrobes", nw - sw, 0);
    @(negedge clk);
    chk("both_idle", bus.busy, 0);
    // reset in cycle 20 of a pull
    bus_q.delete();
    bus.start = 1'b1;
    bus.pull = 1'b1;
    bus.tag = 20'h00012;
    @(negedge clk);
    bus.start = 1'b0;
    bus.pull = 1'b0;
    repeat (19) @(negedge clk);
    chk("pre_rst_busy", bus.busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_state", {bus.qspi_cs_n, bus.busy, bus.done, bus.wstrobe_d, bus.rstrobe_d}, 5'b10000);
    reset = 1'b0;
    nd = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.done || bus.busy) nd++;
    end
    chk("abort_quiet", nd, 0);
    txn(1'b0, 1'b1, 20'h00012, lat);
    chk("repull_lat", lat, 49);
    chk("repull_dread", pack_rd(), 32'h12345678);
    // back-to-back push then pull
    @(negedge clk);
    sw = nw; sr = nr; nd = nboth;
    txn(1'b1, 1'b0, 20'h00001, lat);
    chk("b2b_push_addr", pack_bus(0), 32'h38000004);
    txn(1'b0, 1'b1, 20'h00002, lat);
    chk("b2b_pull_lat", lat, 49);
    chk("b2b_pull_addr", pack_bus(0), 32'hEB000008);
    chk("b2b_cs_gap", last_run >= 4, 1);
    chk("b2b_rstrobes", nr - sr, 8);
    chk("b2b_wstrobes", nw - sw, 8);
    chk("b2b_dread", pack_rd(), 32'h12345678);
    chk("never_both", nboth - nd, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
